phase_vector_search: RTL
========================

# phase_vector_search

Scans the rotating phase-vector register array for a candidate toggle phase vector and reports whether it is already present. It rotates the array one full turn, so the array ends in its original alignment. At the end of the scan it emits the `valid_second_round` / `valid_index_readout` pair that the phase-add stage consumes to decide whether to append a new vector. It sits upstream of the phase-add stage and shares the rotation control of the phase register array with it.

## Interface
- NUM_QUBIT, 3, width of one phase vector
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle request to search; ignored while busy
- query_vector  input  NUM_QUBIT  candidate toggle phase vector, packed; bit NUM_QUBIT-1 is qubit 0
- counter_valid_vector  input  32  number of valid entries currently in the array
- phase_left_out  input  unpacked [0:NUM_QUBIT-1]  head entry of the rotating array
- rotate_en  output  1  requests one left rotation of the array this cycle
- busy  output  1  search in progress
- valid_second_round  output  1  one-cycle pulse: search result valid
- valid_index_readout  output  1  match found; meaningful only with valid_second_round
- match_index  output  32  rotation position of the first match; 0 if none
- match_count  output  32  total matches (only with PHASE_SEARCH_MATCH_COUNT_EN)

## Operation
- FSM states are IDLE, SCAN and REPORT.
- IDLE: on start=1, latch query_vector (remapped to unpacked order) and counter_valid_vector into n_lat. Clear scan_idx, found and match_index.
  - If n_lat==0, go to REPORT. Otherwise go to SCAN.
- SCAN: rotate_en=1 every cycle.
  - Compare phase_left_out with the latched query, all NUM_QUBIT bits equal.
  - On the first equality, set found=1 and match_index=scan_idx. Later equalities do not overwrite match_index.
  - scan_idx increments each cycle. When scan_idx==n_lat-1, go to REPORT.
  - The equality check on the last entry counts toward the result.
- REPORT: valid_second_round=1 and valid_index_readout=found for exactly one cycle. Return to IDLE.
- The array is rotated exactly n_lat times per search, which restores its alignment.
- Changes to counter_valid_vector during a search are ignored; the latched n_lat governs the scan.
- start in SCAN or REPORT is dropped, not queued.
- Arithmetic: scan_idx and match_index are 32-bit unsigned. n_lat values above 2^32-1 cannot occur.

## Timing
- Reset values: all outputs 0. State IDLE, scan_idx=0, found=0.
- start sampled at edge T, n_lat=N>0:
  - SCAN occupies cycles T+1 .. T+N, with rotate_en high for N cycles.
  - REPORT is cycle T+N+1.
  - Latency from start to result is N+1 cycles.
- N=0: REPORT at T+1 with valid_index_readout=0 and rotate_en never asserted.
- busy is high from T+1 through the REPORT cycle inclusive.
- start is accepted again in the first IDLE cycle after REPORT.
- Outputs rotate_en, valid_second_round and busy are decoded from state only (Moore). match_index and valid_index_readout are registered.
- Reset asserted mid-scan aborts immediately: outputs go to 0 and rotation stops. The array may be left misaligned; the array owner resets alongside.

## Configuration
- PHASE_SEARCH_MATCH_COUNT_EN defined:
  - match_count port exists and increments on every equality in SCAN.
  - It is cleared on search start and is valid in REPORT.
  - It saturates at 32'hFFFFFFFF.
- PHASE_SEARCH_MATCH_COUNT_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package phase_search_pkg holds:
  - the state enum (IDLE, SCAN, REPORT);
  - the 32-bit count width constant;
  - the packed-to-unpacked vector mapping function, also usable by the phase-add stage.
- One sub-module, phase_vector_compare: a registered-free NUM_QUBIT-bit equality over an unpacked vector pair, with output eq.

## Test plan
- NUM_QUBIT=3, array {3'b001,3'b010,3'b100}, N=3, query 3'b010:
  - rotate_en high 3 cycles; REPORT at T+4 with valid_index_readout=1 and match_index=1.
  - Array order is restored.
- Same array, query 3'b111: REPORT at T+4 with valid_index_readout=0 and match_index=0.
- N=0, start: REPORT at T+1, valid_index_readout=0, zero rotate_en cycles.
- Array {3'b101,3'b101,3'b011}, query 3'b101:
  - match_index=0 and valid_index_readout=1.
  - With PHASE_SEARCH_MATCH_COUNT_EN, match_count=2.
- start pulsed again at T+2 during an N=3 scan, and counter_valid_vector changed to 7 at T+2: ignored; exactly 3 rotations and one REPORT.
- rst asserted at T+2 of an N=5 scan: all outputs 0 next cycle, state IDLE; a new start after release performs a full scan.

Source files
------------

// File: rtl/phase_search_pkg.sv
// Shared types and helpers for the phase-vector search and phase-add stages.
package phase_search_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StReport
    } state_e;

    localparam int unsigned CountWidth = 32;
    localparam int unsigned MaxQubit   = 64;
    localparam int unsigned MaxQubitW  = $clog2(MaxQubit);

    // Packed vectors carry qubit 0 in the MSB; unpacked arrays carry it at index 0.
    function automatic logic packed_to_unpacked_bit(input logic [MaxQubit-1:0] vec,
                                                    input int unsigned width,
                                                    input int unsigned idx);
        return vec[MaxQubitW'(width - 1 - idx)];
    endfunction

endpackage

// File: rtl/phase_vector_compare.sv
// Combinational equality over a pair of unpacked phase vectors.
module phase_vector_compare
    import phase_search_pkg::*;
#(
    parameter int unsigned NUM_QUBIT = 3
) (
    input  logic a [0:NUM_QUBIT-1],
    input  logic b [0:NUM_QUBIT-1],
    output logic eq
);

    always_comb begin
        eq = 1'b1;
        for (int i = 0; i < int'(NUM_QUBIT); i++) begin
            if (a[i] != b[i]) begin
                eq = 1'b0;
            end
        end
    end

endmodule

// File: rtl/phase_vector_search.sv
// Searches the rotating phase-vector array for a query, rotating it one full turn.
// Optional match counter enabled by defining PHASE_SEARCH_MATCH_COUNT_EN.
module phase_vector_search
    import phase_search_pkg::*;
#(
    parameter int unsigned NUM_QUBIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_QUBIT-1:0]  query_vector,
    input  logic [CountWidth-1:0] counter_valid_vector,
    input  logic                  phase_left_out [0:NUM_QUBIT-1],
    output logic                  rotate_en,
    output logic                  busy,
    output logic                  valid_second_round,
    output logic                  valid_index_readout,
`ifdef PHASE_SEARCH_MATCH_COUNT_EN
    output logic [CountWidth-1:0] match_count,
`endif
    output logic [CountWidth-1:0] match_index
);

    state_e                state_q, state_d;
    logic [CountWidth-1:0] scan_idx_q, scan_idx_d;
    logic [CountWidth-1:0] n_lat_q, n_lat_d;
    logic [CountWidth-1:0] match_index_q, match_index_d;
    logic                  found_q, found_d;
    logic                  query_q [0:NUM_QUBIT-1];
    logic                  query_d [0:NUM_QUBIT-1];
    logic                  eq;

    phase_vector_compare #(
        .NUM_QUBIT(NUM_QUBIT)
    ) u_compare (
        .a (phase_left_out),
        .b (query_q),
        .eq(eq)
    );

    always_comb begin
        state_d       = state_q;
        scan_idx_d    = scan_idx_q;
        n_lat_d       = n_lat_q;
        match_index_d = match_index_q;
        found_d       = found_q;
        query_d       = query_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    for (int i = 0; i < int'(NUM_QUBIT); i++) begin
                        query_d[i] = packed_to_unpacked_bit(MaxQubit'(query_vector), NUM_QUBIT,
                                                            i);
                    end
                    n_lat_d       = counter_valid_vector;
                    scan_idx_d    = '0;
                    found_d       = 1'b0;
                    match_index_d = '0;
                    state_d       = (counter_valid_vector == '0) ? StReport : StScan;
                end
            end
            StScan: begin
                // Only the first hit records its position.
                if (eq && !found_q) begin
                    found_d       = 1'b1;
                    match_index_d = scan_idx_q;
                end
                scan_idx_d = scan_idx_q + 1;
                if (scan_idx_q == n_lat_q - 1) begin
                    state_d = StReport;
                end
            end
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            scan_idx_q    <= '0;
            n_lat_q       <= '0;
            match_index_q <= '0;
            found_q       <= 1'b0;
            for (int i = 0; i < int'(NUM_QUBIT); i++) begin
                query_q[i] <= 1'b0;
            end
        end else begin
            state_q       <= state_d;
            scan_idx_q    <= scan_idx_d;
            n_lat_q       <= n_lat_d;
            match_index_q <= match_index_d;
            found_q       <= found_d;
            query_q       <= query_d;
        end
    end

`ifdef PHASE_SEARCH_MATCH_COUNT_EN
    logic [CountWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == StIdle && start) begin
            count_d = '0;
        end else if (state_q == StScan && eq && count_q != '1) begin
            count_d = count_q + 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match_count = count_q;
`endif

    assign rotate_en           = (state_q == StScan);
    assign busy                = (state_q != StIdle);
    assign valid_second_round  = (state_q == StReport);
    assign valid_index_readout = found_q;
    assign match_index         = match_index_q;

endmodule
